// File: rtl/ddr_cmd_pkg.sv
// Shared constants for the DDR command sequencer: one-hot bit positions,
// ras/cas/we pin encodings and the burst FSM state type.
package ddr_cmd_pkg;
  localparam int NCMD = 19;

  localparam int ACT_B  = 18;
  localparam int BST_B  = 17;
  localparam int CFG_B  = 16;
  localparam int CKEH_B = 15;
  localparam int CKEL_B = 14;
  localparam int DPD_B  = 13;
  localparam int DPDX_B = 12;
  localparam int MRR_B  = 11;
  localparam int MRW_B  = 10;
  localparam int PD_B   = 9;
  localparam int PDX_B  = 8;
  localparam int PR_B   = 7;
  localparam int PRA_B  = 6;
  localparam int RD_B   = 5;
  localparam int RDA_B  = 4;
  localparam int REF_B  = 3;
  localparam int SRF_B  = 2;
  localparam int WR_B   = 1;
  localparam int WRA_B  = 0;

  // {ras_n, cas_n, we_n} with act_n high
  localparam logic [2:0] PIN_MRW = 3'b000;
  localparam logic [2:0] PIN_REF = 3'b001;
  localparam logic [2:0] PIN_PR  = 3'b010;
  localparam logic [2:0] PIN_WR  = 3'b100;
  localparam logic [2:0] PIN_RD  = 3'b101;
  localparam logic [2:0] PIN_BST = 3'b110;
  localparam logic [2:0] PIN_NOP = 3'b111;

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} burst_state_e;
endpackage

// File: rtl/ddr_cmd_sequencer_pin_decode.sv
// Combinational decode of raw command pins into a one-hot next-command vector.
// An all-zero vector means NOP.
module ddr_cmd_sequencer_pin_decode
  import ddr_cmd_pkg::*;
(
  input  logic            cs_n,
  input  logic            act_n,
  input  logic            ras_n,
  input  logic            cas_n,
  input  logic            we_n,
  input  logic            cke,
  input  logic            cke_q,
  input  logic            a10,
  output logic [NCMD-1:0] cmd
);
  always_comb begin
    cmd = '0;
    if (!cs_n) begin
      if (!act_n) cmd[ACT_B] = 1'b1;
      else begin
        case ({ras_n, cas_n, we_n})
          PIN_MRW: cmd[MRW_B] = 1'b1;
          PIN_REF: cmd[cke ? REF_B : SRF_B] = 1'b1;
          PIN_PR:  cmd[a10 ? PRA_B : PR_B] = 1'b1;
          PIN_WR:  cmd[a10 ? WRA_B : WR_B] = 1'b1;
          PIN_RD:  cmd[a10 ? RDA_B : RD_B] = 1'b1;
          PIN_BST: cmd[BST_B] = 1'b1;
          default: ;
        endcase
      end
    end else if (cke_q && !cke) begin
      cmd[PD_B] = 1'b1;
    end else if (!cke_q && cke) begin
      cmd[PDX_B] = 1'b1;
    end
  end
endmodule

// File: rtl/ddr_cmd_sequencer.sv
// Registers decoded DDR commands, stretches RD/WR to BL beats with wrapping
// column increment, and tracks open-row state. PROTOCOL_CHECK_EN enables err.
module ddr_cmd_sequencer
  import ddr_cmd_pkg::*;
#(
  parameter int ROWS  = 131072,
  parameter int COLS  = 1024,
  parameter int BL    = 8,
  parameter int ADDRW = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt,
  input  logic                     cs_n,
  input  logic                     act_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic                     cke,
  input  logic [ADDRW-1:0]         addr,
  output logic [NCMD-1:0]          commands,
  output logic [$clog2(ROWS)-1:0]  row,
  output logic [$clog2(COLS)-1:0]  column,
  output logic                     busy,
  output logic                     err
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int BW = $clog2(BL);

`ifdef PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  burst_state_e    state_q, state_d;
  logic [NCMD-1:0] dec, cmd_q, cmd_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            row_open, open_d, err_q, err_d, cke_q;
  logic            burst_live, auto_q, open_eff, is_rw;

  ddr_cmd_sequencer_pin_decode u_dec (
    .cs_n  (cs_n),
    .act_n (act_n),
    .ras_n (ras_n),
    .cas_n (cas_n),
    .we_n  (we_n),
    .cke   (cke),
    .cke_q (cke_q),
    .a10   (addr[10]),
    .cmd   (dec)
  );

  assign burst_live = (state_q == ST_BURST) && (cnt_q != '0);
  assign auto_q     = cmd_q[RDA_B] | cmd_q[WRA_B];
  // A burst finishing on this edge releases its auto-precharge before the new command is judged
  assign open_eff   = row_open && !((state_q == ST_BURST) && auto_q);
  assign is_rw      = dec[RD_B] | dec[RDA_B] | dec[WR_B] | dec[WRA_B];

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    open_d  = row_open;
    err_d   = 1'b0;
    if (burst_live) begin
      if (dec[BST_B]) begin
        cmd_d        = '0;
        cmd_d[BST_B] = 1'b1;
        state_d      = ST_IDLE;
        if (auto_q) open_d = 1'b0;
      end else begin
        col_d = {col_q[CW-1:BW], col_q[BW-1:0] + BW'(1)};
        cnt_d = cnt_q - BW'(1);
        err_d = CHK && (|dec);
      end
    end else begin
      state_d = ST_IDLE;
      cmd_d   = '0;
      open_d  = open_eff;
      if (dec[ACT_B]) begin
        if (CHK && open_eff) err_d = 1'b1;
        else begin
          cmd_d  = dec;
          row_d  = addr[RW-1:0];
          open_d = 1'b1;
        end
      end else if (is_rw) begin
        if (CHK && !open_eff) err_d = 1'b1;
        else begin
          cmd_d   = dec;
          col_d   = addr[CW-1:0];
          cnt_d   = BW'(BL - 1);
          state_d = ST_BURST;
        end
      end else begin
        cmd_d = dec;
        if (dec[PR_B] || dec[PRA_B]) open_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      row_open <= 1'b0;
      err_q    <= 1'b0;
      cke_q    <= 1'b1;
    end else if (!halt) begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      row_open <= open_d;
      err_q    <= err_d;
      cke_q    <= cke;
    end
  end

  assign commands = cmd_q;
  assign row      = row_q;
  assign column   = col_q;
  assign busy     = (state_q == ST_BURST);
  assign err      = err_q;
endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Randomized and directed bench for ddr_cmd_sequencer against a
// transaction-level reference model of the command/burst rules.
module tb_ddr_cmd_sequencer;
  import ddr_cmd_pkg::*;

`ifdef PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int BL = 8;
  localparam int C_DES = 0, C_NOP = 1, C_ACT = 2, C_MRW = 3, C_REF = 4,
                 C_PR = 5, C_WR = 6, C_RD = 7, C_BST = 8;

  logic        clk = 1'b0, rst = 1'b1, halt = 1'b0;
  logic        cs_n = 1'b1, act_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, cke = 1'b1;
  logic [16:0] addr = '0;
  logic [18:0] commands;
  logic [16:0] row;
  logic [9:0]  column;
  logic        busy, err;

  ddr_cmd_sequencer dut (
    .clk(clk), .rst(rst), .halt(halt), .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .cke(cke), .addr(addr), .commands(commands),
    .row(row), .column(column), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [18:0] m_cmd;
  logic [16:0] m_row;
  logic [9:0]  m_col;
  logic        m_busy, m_err, m_open, m_auto, m_cke;
  int          m_left, m_start, m_k;
  int          checks = 0, fails = 0;

  logic [47:0] obs, exp_v;
  assign obs   = {commands, row, column, busy, err};
  assign exp_v = {m_cmd, m_row, m_col, m_busy, m_err};

  task automatic model_reset();
    m_cmd = '0; m_row = '0; m_col = '0; m_busy = 0; m_err = 0;
    m_open = 0; m_auto = 0; m_cke = 1; m_left = 0; m_start = 0; m_k = 0;
  endtask

  function automatic int decode();
    if (cs_n) return (m_cke && !cke) ? PD_B : ((!m_cke && cke) ? PDX_B : -1);
    if (!act_n) return ACT_B;
    case ({ras_n, cas_n, we_n})
      3'b000:  return MRW_B;
      3'b001:  return cke ? REF_B : SRF_B;
      3'b010:  return addr[10] ? PRA_B : PR_B;
      3'b100:  return addr[10] ? WRA_B : WR_B;
      3'b101:  return addr[10] ? RDA_B : RD_B;
      3'b110:  return BST_B;
      default: return -1;
    endcase
  endfunction

  task automatic pins(input int c, input logic [16:0] a);
    cs_n = 1'b0; act_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; addr = a;
    case (c)
      C_DES: cs_n = 1'b1;
      C_ACT: act_n = 1'b0;
      C_MRW: {ras_n, cas_n, we_n} = 3'b000;
      C_REF: {ras_n, cas_n, we_n} = 3'b001;
      C_PR:  {ras_n, cas_n, we_n} = 3'b010;
      C_WR:  {ras_n, cas_n, we_n} = 3'b100;
      C_RD:  {ras_n, cas_n, we_n} = 3'b101;
      C_BST: {ras_n, cas_n, we_n} = 3'b110;
      default: ;
    endcase
  endtask

  // advance model by one edge from the current pins, then clock the DUT
  task automatic tick();
    int d;
    if (!halt) begin
      d = decode();
      m_err = 0;
      if (m_left > 0) begin
        if (d == BST_B) begin
          m_cmd = 19'(1) << BST_B; m_left = 0; m_busy = 0;
          if (m_auto) m_open = 0;
        end else begin
          m_k++; m_left--;
          m_col = 10'((m_start / BL) * BL + (m_start + m_k) % BL);
          if (d >= 0) m_err = CHK;
        end
      end else begin
        if (m_busy && m_auto) m_open = 0;
        m_busy = 0; m_cmd = '0;
        if (d == ACT_B) begin
          if (CHK && m_open) m_err = 1;
          else begin m_cmd = 19'(1) << d; m_row = addr; m_open = 1; end
        end else if (d == RD_B || d == RDA_B || d == WR_B || d == WRA_B) begin
          if (CHK && !m_open) m_err = 1;
          else begin
            m_cmd = 19'(1) << d; m_start = int'(addr[9:0]); m_k = 0; m_col = addr[9:0];
            m_left = BL - 1; m_busy = 1; m_auto = (d == RDA_B || d == WRA_B);
          end
        end else if (d >= 0) begin
          m_cmd = 19'(1) << d;
          if (d == PR_B || d == PRA_B) m_open = 0;
        end
      end
      m_cke = cke;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (obs !== 48'h0) begin fails++; $display("FAIL reset_hold: got %h want 0", obs); end
    @(posedge clk); #1; rst = 1'b0; model_reset();
    pins(C_NOP, '0); tick();
    checks++;
    if (obs !== 48'h0) begin fails++; $display("FAIL reset_idle: got %h want 0", obs); end
  endtask

  task automatic test_rd_burst();
    logic [9:0] cols [8] = '{10'h3FE, 10'h3FF, 10'h3F8, 10'h3F9, 10'h3FA, 10'h3FB, 10'h3FC, 10'h3FD};
    pins(C_ACT, 17'h155); tick();
    checks++;
    if (row !== 17'h155 || commands !== (19'(1) << ACT_B) || obs !== exp_v) begin
      fails++; $display("FAIL rd_act: got %h want %h row %h", obs, exp_v, row);
    end
    pins(C_RD, 17'h3FE);
    for (int i = 0; i < 8; i++) begin
      tick(); pins(C_NOP, '0);
      checks++;
      if (column !== cols[i] || commands !== (19'(1) << RD_B) || busy !== 1'b1 || err !== 1'b0 || obs !== exp_v) begin
        fails++; $display("FAIL rd_beat%0d: got %h want %h col %h/%h", i, obs, exp_v, column, cols[i]);
      end
    end
    tick();
    checks++;
    if (commands !== '0 || busy !== 1'b0 || obs !== exp_v) begin
      fails++; $display("FAIL rd_end: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_wra_collision();
    pins(C_WR, 17'h400);
    for (int i = 0; i < 8; i++) begin
      tick();
      pins((i == 2) ? C_WR : C_NOP, 17'h020);
      checks++;
      if (commands !== (19'(1) << WRA_B) || err !== ((i == 3) ? CHK : 1'b0) || obs !== exp_v) begin
        fails++; $display("FAIL wra_beat%0d: got %h want %h", i, obs, exp_v);
      end
    end
    pins(C_NOP, '0); tick();
    pins(C_RD, 17'h040); tick();
    checks++;
    if (err !== CHK || obs !== exp_v) begin
      fails++; $display("FAIL rd_closed: got %h want %h err %b", obs, exp_v, err);
    end
    pins(C_NOP, '0);
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_bst();
    pins(C_PR, '0); tick();
    pins(C_ACT, 17'h0AA); tick();
    pins(C_RD, 17'h010); tick();
    pins(C_NOP, '0); tick(); tick();
    pins(C_BST, '0); tick();
    checks++;
    if (commands !== (19'(1) << BST_B) || busy !== 1'b0 || obs !== exp_v) begin
      fails++; $display("FAIL bst_cut: got %h want %h", obs, exp_v);
    end
    pins(C_NOP, '0); tick();
    checks++;
    if (commands !== '0 || obs !== exp_v) begin fails++; $display("FAIL bst_pulse: got %h want %h", obs, exp_v); end
    pins(C_PR, '0); tick();
    pins(C_ACT, 17'h1234); tick();
    checks++;
    if (err !== 1'b0 || commands !== (19'(1) << ACT_B) || row !== 17'h1234 || obs !== exp_v) begin
      fails++; $display("FAIL bst_next_act: got %h want %h", obs, exp_v);
    end
    pins(C_NOP, '0);
  endtask

  task automatic test_halt();
    int rd_hi = 0;
    logic [47:0] held = '0;
    for (int i = 0; i < 16; i++) begin
      pins((i == 0) ? C_RD : C_NOP, 17'h100);
      halt = (i >= 2 && i <= 5);
      tick();
      if (commands[RD_B]) rd_hi++;
      if (i == 1) held = obs;
      checks++;
      if (obs !== exp_v || (halt && obs !== held)) begin
        fails++; $display("FAIL halt_cyc%0d: got %h want %h held %h", i, obs, exp_v, held);
      end
    end
    halt = 1'b0;
    checks++;
    if (rd_hi !== 12) begin fails++; $display("FAIL halt_count: got %0d want 12", rd_hi); end
  endtask

  task automatic test_reset_mid();
    pins(C_RD, 17'h200); tick();
    pins(C_NOP, '0); tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (commands !== '0 || busy !== 1'b0 || column !== '0 || row !== '0) begin
      fails++; $display("FAIL reset_mid: got %h want 0", obs);
    end
    model_reset();
    #1 rst = 1'b0;
    pins(C_RD, 17'h010); tick();
    checks++;
    if (err !== CHK || obs !== exp_v) begin
      fails++; $display("FAIL rd_after_reset: got %h want %h", obs, exp_v);
    end
    pins(C_NOP, '0);
    for (int i = 0; i < 9; i++) tick();
  endtask

  task automatic test_cke();
    pins(C_DES, '0); cke = 1'b0; tick();
    checks++;
    if (commands !== (19'(1) << PD_B) || obs !== exp_v) begin fails++; $display("FAIL pd: got %h want %h", obs, exp_v); end
    tick();
    checks++;
    if (commands !== '0 || obs !== exp_v) begin fails++; $display("FAIL pd_once: got %h want %h", obs, exp_v); end
    cke = 1'b1; tick();
    checks++;
    if (commands !== (19'(1) << PDX_B) || obs !== exp_v) begin fails++; $display("FAIL pdx: got %h want %h", obs, exp_v); end
    pins(C_REF, '0); cke = 1'b0; tick();
    checks++;
    if (commands !== (19'(1) << SRF_B) || obs !== exp_v) begin fails++; $display("FAIL srf: got %h want %h", obs, exp_v); end
    pins(C_NOP, '0); cke = 1'b1; tick();
    checks++;
    if (commands !== '0 || obs !== exp_v) begin fails++; $display("FAIL cke_cs_low: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 15);
      pins((r > 8) ? C_NOP : r, 17'($urandom));
      if ($urandom_range(0, 19) == 0) cke = ~cke;
      halt = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (obs !== exp_v || $countones(commands) > 1) begin
        fails++; $display("FAIL random_cyc%0d: got %h want %h", i, obs, exp_v);
      end
    end
    halt = 1'b0; cke = 1'b1; pins(C_NOP, '0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rd_burst();
    test_wra_collision();
    test_bst();
    test_halt();
    test_reset_mid();
    test_cke();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
